// File: rtl/gated_mult_n_pkg.sv
// mult_pkg: shared FSM state encoding and counter-width helper for gated_mult_n.
// No ports; imported by gated_mult_n.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/gated_mult_n_adder_row.sv
// gated_adder_row_n: combinational WIDTH-bit ripple row of gated full-adder cells.
// Ports: a (multiplicand), mgate (gate applied to every a bit), b (addend),
//        cin (carry in) -> sum (WIDTH bits), cout (carry out of the top cell).
module gated_adder_row_n #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic             mgate,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic x;
        assign x        = a[i] & mgate;
        assign sum[i]   = x ^ b[i] ^ c[i];
        assign c[i+1]   = (x & b[i]) | (c[i] & (x ^ b[i]));
    end

endmodule

// File: rtl/gated_mult_n.sv
// gated_mult_n: sequential shift-and-add multiplier (one multiplier bit per clock)
// with optional accumulate into the held product.
// Ports: clk, rst_n (sync, active low), start, accumulate, a, b (WIDTH-bit unsigned)
//        -> busy (RUN/ACC), done (one-cycle pulse), product (2*WIDTH), ovf (accumulate carry).
module gated_mult_n
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               accumulate,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               ovf
);

    localparam int CW = clog2(WIDTH);

    logic [1:0]       state, nxt;
    logic [WIDTH-1:0] a_reg, b_reg, b_nxt, sum;
    logic [WIDTH:0]   hi, hi_nxt;
    logic [CW-1:0]    cnt;
    logic             acc_reg, cout, accept, last;

    assign accept = start && (state == ST_IDLE || state == ST_DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    // hi[WIDTH] is always zero after a shift, so using it as the carry-in
    // leaves the sum unchanged.
    gated_adder_row_n #(.WIDTH(WIDTH)) u_row (
        .a     (a_reg),
        .mgate (b_reg[0]),
        .b     (hi[WIDTH-1:0]),
        .cin   (hi[WIDTH]),
        .sum   (sum),
        .cout  (cout)
    );

    // {carry, sum, b_reg} shifted right by one: the carry lands at the top of hi.
    assign hi_nxt = {1'b0, cout, sum[WIDTH-1:1]};
    assign b_nxt  = {sum[0], b_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: nxt = start ? ST_RUN : ST_IDLE;
            ST_RUN:  nxt = last ? (acc_reg ? ST_ACC : ST_DONE) : ST_RUN;
            ST_ACC:  nxt = ST_DONE;
            default: nxt = start ? ST_RUN : ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_RUN) || (state == ST_ACC);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            hi      <= '0;
            cnt     <= '0;
            acc_reg <= 1'b0;
            product <= '0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            acc_reg <= accumulate;
            hi      <= '0;
            cnt     <= '0;
        end else if (state == ST_RUN) begin
            hi    <= hi_nxt;
            b_reg <= b_nxt;
            cnt   <= cnt + 1'b1;
            if (last && !acc_reg) begin
                product <= {hi_nxt[WIDTH-1:0], b_nxt};
                ovf     <= 1'b0;
            end
        end else if (state == ST_ACC) begin
            {ovf, product} <= {1'b0, product} + {1'b0, hi[WIDTH-1:0], b_reg};
        end
    end

endmodule

// File: tb/tb_gated_mult_n.sv
// tb_gated_mult_n: directed self-checking bench for gated_mult_n at WIDTH=8.
// No ports.
module tb_gated_mult_n;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           accumulate = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done, ovf;
    logic [2*W-1:0] product;
    int             checks = 0;
    int             errors = 0;

    gated_mult_n #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .accumulate (accumulate),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tacc, input int lat, input logic [15:0] p, input logic o);
        int n;
        a = ta;
        b = tb;
        accumulate = tacc;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_prod"}, 32'(product), 32'(p));
        chk({tag, "_ovf"}, 32'(ovf), 32'(o));
        step();
        chk({tag, "_done_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prod", 32'(product), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        step();

        do_op("m13x11", 8'd13, 8'd11, 1'b0, 8, 16'd143, 1'b0);
        do_op("m255x255", 8'd255, 8'd255, 1'b0, 8, 16'hFE01, 1'b0);
        do_op("m0xA5", 8'd0, 8'hA5, 1'b0, 8, 16'd0, 1'b0);
        do_op("m1x255", 8'd1, 8'd255, 1'b0, 8, 16'd255, 1'b0);

        do_op("acc_base", 8'd13, 8'd11, 1'b0, 8, 16'd143, 1'b0);
        do_op("acc200", 8'd200, 8'd200, 1'b1, 9, 16'd40143, 1'b0);

        do_op("ovf_base", 8'd255, 8'd255, 1'b0, 8, 16'hFE01, 1'b0);
        do_op("ovf_acc", 8'd255, 8'd255, 1'b1, 9, 16'hFC02, 1'b1);

        // start pulsed mid-run must be ignored; product holds until completion
        a = 8'd13;
        b = 8'd11;
        accumulate = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_hold_prod", 32'(product), 32'hFC02);
        chk("ign_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("ign_lat", 32'(n + 3), 32'd8);
        chk("ign_prod", 32'(product), 32'd143);
        chk("ign_ovf", 32'(ovf), 32'd0);
        step();
        chk("ign_idle", 32'(busy | done), 32'd0);

        // back-to-back: start during DONE is accepted at that edge
        a = 8'd1;
        b = 8'd255;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n);
        chk("b2b_lat1", 32'(n), 32'd8);
        chk("b2b_prod1", 32'(product), 32'd255);
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_done_gap", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_done(n);
        chk("b2b_lat2", 32'(n), 32'd8);
        chk("b2b_prod2", 32'(product), 32'd15);
        step();

        // reset mid-run clears everything, then accumulate adds to zero
        a = 8'd255;
        b = 8'd255;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_prod", 32'(product), 32'd0);
        chk("mrst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        step();
        chk("mrst_stay_idle", 32'(busy | done), 32'd0);
        do_op("post_rst_acc", 8'd13, 8'd11, 1'b1, 9, 16'd143, 1'b0);
        do_op("post_rst_plain", 8'd13, 8'd11, 1'b0, 8, 16'd143, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gated_mult_n.md
# gated_mult_n

Parametrised sequential shift-and-add multiplier with optional accumulate, built from one row of gated full-adder cells. The block takes one WIDTH-bit operand pair per `start` request and retires one multiplier bit per clock. It returns the 2*WIDTH-bit product with a single-cycle `done` pulse. It replaces the combinational array-multiplier rows in the arithmetic datapath wherever area matters more than latency.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- clk  input  1  rising-edge clock; the block uses this single clock only
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  input  1  request; accepted only in IDLE or DONE
- accumulate  input  1  sampled with start; 1 = add the new product to the held product
- a  input  WIDTH  multiplicand, unsigned, sampled on the accept edge
- b  input  WIDTH  multiplier, unsigned, sampled on the accept edge
- busy  output  1  high in RUN and ACC
- done  output  1  high exactly one cycle, in DONE
- product  output  2*WIDTH  result register, held until the next completion
- ovf  output  1  carry-out of the accumulate add, updated at each completion

## Operation
- States: IDLE, RUN, ACC, DONE.
- IDLE/DONE with start=1: latch a, b and accumulate; clear hi (WIDTH+1 bits) and bit counter; go to RUN.
- DONE with start=0: go to IDLE.
- In RUN, each step does the following:
  - Gate: the gated adder row forms sum = hi + (a_reg AND b_reg[0]), where b_reg[0] is the gate.
  - Shift: {hi, b_reg} shifts right one bit, and the adder carry enters hi's MSB.
  - Count: the counter increments.
- After step WIDTH-1, {hi[WIDTH-1:0], b_reg} holds a*b.
  - If accumulate_reg=0: go to DONE.
  - If accumulate_reg=1: go to ACC.
- Result on entry to DONE:
  - Plain request: product <= a*b; ovf <= 0.
  - ACC request: product <= (product + a*b) mod 2^(2*WIDTH); ovf <= carry-out. ACC lasts one cycle, then DONE.
- Ignored requests: start while busy is ignored and not queued; a, b and accumulate are don't-care when start=0.
- Held outputs: product and ovf change only on entry to DONE.
- Arithmetic: all arithmetic is unsigned, with no sign extension.

## Timing
- Reset (rst_n=0 at an edge) → state IDLE, busy=0, done=0, product=0, ovf=0, counter=0. This takes priority over every other action, including mid-RUN; no partial result appears on product.
- Let edge E0 accept start.
  - busy is high from E0 until the edge that enters DONE.
  - Plain request: DONE is entered at edge E(WIDTH), so done is high in the cycle after E(WIDTH). Latency is WIDTH cycles.
  - Accumulate request: DONE is entered at E(WIDTH+1). Latency is WIDTH+1 cycles.
- Back-to-back requests: start asserted during DONE is accepted at that edge. One operation per WIDTH+1 cycles (plain) or WIDTH+2 cycles (accumulate) is sustained.
- done never stays high for two consecutive cycles, even with back-to-back requests.
- Accumulate after reset adds to product=0.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- The shared package `mult_pkg` holds:
  - the state encoding localparams (ST_IDLE, ST_RUN, ST_ACC, ST_DONE; 2 bits);
  - the counter-width function clog2.
- Sub-module `gated_adder_row_n #(WIDTH)` is the combinational WIDTH-bit ripple row of gated full-adder cells.
  - Ports: a, mgate, b, cin → sum, cout.
  - Each cell computes (a_i AND mgate) + b_i + carry.
  - It is instantiated once for the shift-add step.
- The ACC-state 2*WIDTH-bit add is a plain registered adder in the top level.

## Test plan
- WIDTH=8, a=13, b=11, accumulate=0 → done exactly 8 cycles after the accept edge, product=143 (0x008F), ovf=0.
- Corner operands:
  - a=255, b=255 → product=0xFE01.
  - a=0, b=0xA5 → product=0.
  - a=1, b=255 → product=255.
- Accumulate: first plain 13*11 (product 143), then a=200, b=200, accumulate=1 → done 9 cycles after accept, product=40143, ovf=0.
- Overflow: plain 255*255, then 255*255 with accumulate=1 → product=0xFC02, ovf=1.
- Busy/back-to-back:
  - Pulse start with a=3, b=5 at cycle 3 of a run → ignored; the original result is unchanged.
  - Assert start during DONE → new run accepted at that edge; done pulses never merge.
- Reset mid-RUN at cycle 4 of 255*255 → the next edge shows IDLE, busy=0, done=0, product=0, ovf=0. A fresh 13*11 then completes correctly (143).
